// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Build option: CLKDIV_ODD_50_EN selects the half-length rule for exact 50% duty on odd divisors.
package clkdiv_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
    endfunction

    // Number of counter values (from 0) for which the posedge waveform is high.
    function automatic logic [31:0] half_len(input logic [31:0] n, input logic odd50);
        if (odd50 && n[0]) begin
            return (n - 32'd1) >> 1;
        end
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_shadow.sv
// Divisor shadow register: captures and clamps loads, and applies them at a period boundary or while idle.
module clkdiv_shadow
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             boundary,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic [CNT_W-1:0] div_cur,
    output logic [CNT_W-1:0] div_nxt,
    output logic             pending
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] load_val;
    logic             apply;

    always_comb begin
        load_val  = CNT_W'(clamp_div(32'(div_in)));
        apply     = boundary | ~en;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        div_cur_d = div_cur_q;
        if (div_load) begin
            shadow_d = load_val;
        end
        // A load presented on the apply cycle bypasses the shadow so it is never delayed a period.
        if (apply) begin
            pending_d = 1'b0;
            if (div_load) begin
                div_cur_d = load_val;
            end else if (pending_q) begin
                div_cur_d = shadow_q;
            end
        end else if (div_load) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q  <= '0;
            div_cur_q <= CNT_W'(DEF_DIV);
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            div_cur_q <= div_cur_d;
            pending_q <= pending_d;
        end
    end

    assign div_cur = div_cur_q;
    assign div_nxt = div_cur_d;
    assign pending = pending_q;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable integer clock divider producing a divided waveform and a first-cycle period tick.
// Build option: CLKDIV_ODD_50_EN adds a negedge stage giving exact 50% duty for odd divisors.
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             pending
);

`ifdef CLKDIV_ODD_50_EN
    localparam logic ODD50 = 1'b1;
`else
    localparam logic ODD50 = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] half;
    logic             last;

    clkdiv_shadow #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (last),
        .div_load (div_load),
        .div_in   (div_in),
        .div_cur  (div_cur),
        .div_nxt  (div_nxt),
        .pending  (pending)
    );

    always_comb begin
        last   = (cnt_q == (div_cur - CNT_W'(1)));
        half   = CNT_W'(half_len(32'(div_nxt), ODD50));
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        pos_d  = 1'b0;
        if (en) begin
            cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
            tick_d = last;
            pos_d  = (cnt_d < half);
        end else begin
            // Primed so the first enabled edge wraps to 0 and starts a full period.
            cnt_d = div_nxt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_W'(DEF_DIV - 1);
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

`ifdef CLKDIV_ODD_50_EN
    logic neg_q, neg_d;

    assign neg_d = en & div_cur[0] & pos_q;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign div_out = pos_q | neg_q;
`else
    assign div_out = pos_q;
`endif

    assign tick = tick_q;

endmodule
